// File: rtl/noc_pkg.sv
// Shared NoC routing types: direction encoding, one-hot route constants,
// wormhole FSM states and a generic xy coordinate helper.
package noc;

    // Port indices into a one-hot route vector.
    localparam int kNorthPort = 0;
    localparam int kSouthPort = 1;
    localparam int kWestPort  = 2;
    localparam int kEastPort  = 3;
    localparam int kLocalPort = 4;

    typedef enum logic [2:0] {
        DirNorth = 3'd0,
        DirSouth = 3'd1,
        DirWest  = 3'd2,
        DirEast  = 3'd3,
        DirLocal = 3'd4
    } direction_t;

    // One-hot route vectors. North decrements y, East increments x.
    localparam logic [4:0] goNorth = 5'b00001;
    localparam logic [4:0] goSouth = 5'b00010;
    localparam logic [4:0] goWest  = 5'b00100;
    localparam logic [4:0] goEast  = 5'b01000;
    localparam logic [4:0] goLocal = 5'b10000;

    typedef enum logic {
        StIdle = 1'b0,
        StPkt  = 1'b1
    } state_t;

    // Coordinates wide enough for any supported mesh; narrower meshes
    // zero-extend into it.
    localparam int kMaxCoordBits = 8;

    typedef struct packed {
        logic [kMaxCoordBits-1:0] x;
        logic [kMaxCoordBits-1:0] y;
    } xy_t;

    function automatic xy_t make_xy(input int unsigned x, input int unsigned y,
                                    input int unsigned bits);
        xy_t r;
        int unsigned mask;
        mask = (bits >= 32) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 32'd1);
        r.x  = kMaxCoordBits'(x & mask);
        r.y  = kMaxCoordBits'(y & mask);
        return r;
    endfunction

    function automatic logic [4:0] dir_to_onehot(input direction_t d);
        logic [4:0] r;
        case (d)
            DirNorth: r = goNorth;
            DirSouth: r = goSouth;
            DirWest:  r = goWest;
            DirEast:  r = goEast;
            default:  r = goLocal;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lookahead_route_calc.sv
// Combinational lookahead route: steps this router's position one hop along
// the current route, then picks the output port at that next router.
module lookahead_route_calc
    import noc::*;
#(
    parameter int X_BITS   = 3,
    parameter int Y_BITS   = 3,
    parameter int MESH_X   = 8,
    parameter int MESH_Y   = 8,
    parameter int TORUS    = 0,
    parameter int YX_ORDER = 1
) (
    input  logic [X_BITS-1:0] pos_x,
    input  logic [Y_BITS-1:0] pos_y,
    input  logic [4:0]        route,
    input  logic [X_BITS-1:0] dest_x,
    input  logic [Y_BITS-1:0] dest_y,
    output logic [4:0]        next_route,
    output logic              route_err
);

    // One extra bit so mesh sizes equal to 2**BITS and wrap sums fit.
    localparam logic [X_BITS:0] MX     = (X_BITS+1)'(MESH_X);
    localparam logic [Y_BITS:0] MY     = (Y_BITS+1)'(MESH_Y);
    localparam logic [X_BITS:0] HALF_X = (X_BITS+1)'(MESH_X / 2);
    localparam logic [Y_BITS:0] HALF_Y = (Y_BITS+1)'(MESH_Y / 2);

    logic [X_BITS:0] px, dx, npx, fwd_x;
    logic [Y_BITS:0] py, dy, npy, fwd_y;
    logic            force_local, edge_err, range_err;
    direction_t      x_dir, y_dir, sel;

    // Step one hop, then resolve the dimension order from the next position.
    always_comb begin
        px          = {1'b0, pos_x};
        py          = {1'b0, pos_y};
        dx          = {1'b0, dest_x};
        dy          = {1'b0, dest_y};
        npx         = px;
        npy         = py;
        force_local = 1'b0;
        edge_err    = 1'b0;
        fwd_x       = '0;
        fwd_y       = '0;
        x_dir       = DirLocal;
        y_dir       = DirLocal;
        sel         = DirLocal;

        case (route)
            goNorth: begin
                if (py == '0) begin
                    if (TORUS != 0) npy = MY - 1'b1;
                    else            edge_err = 1'b1;
                end else begin
                    npy = py - 1'b1;
                end
            end
            goSouth: begin
                if (py == MY - 1'b1) begin
                    if (TORUS != 0) npy = '0;
                    else            edge_err = 1'b1;
                end else begin
                    npy = py + 1'b1;
                end
            end
            goWest: begin
                if (px == '0) begin
                    if (TORUS != 0) npx = MX - 1'b1;
                    else            edge_err = 1'b1;
                end else begin
                    npx = px - 1'b1;
                end
            end
            goEast: begin
                if (px == MX - 1'b1) begin
                    if (TORUS != 0) npx = '0;
                    else            edge_err = 1'b1;
                end else begin
                    npx = px + 1'b1;
                end
            end
            default: force_local = 1'b1;
        endcase

        range_err = (dx >= MX) || (dy >= MY);

        // On a torus the forward (E/S) ring distance decides; ties go E/S.
        if (TORUS != 0) begin
            fwd_x = (dx >= npx) ? (dx - npx) : (dx + MX - npx);
            fwd_y = (dy >= npy) ? (dy - npy) : (dy + MY - npy);
            x_dir = (fwd_x <= HALF_X) ? DirEast  : DirWest;
            y_dir = (fwd_y <= HALF_Y) ? DirSouth : DirNorth;
        end else begin
            x_dir = (dx > npx) ? DirEast  : DirWest;
            y_dir = (dy > npy) ? DirSouth : DirNorth;
        end

        if (force_local || edge_err || range_err) begin
            sel = DirLocal;
        end else if (YX_ORDER != 0) begin
            if (dy != npy)      sel = y_dir;
            else if (dx != npx) sel = x_dir;
            else                sel = DirLocal;
        end else begin
            if (dx != npx)      sel = x_dir;
            else if (dy != npy) sel = y_dir;
            else                sel = DirLocal;
        end

        next_route = dir_to_onehot(sel);
        route_err  = edge_err || range_err;
    end

endmodule

// File: rtl/lookahead_route_unit.sv
// Lookahead routing pipeline stage: one valid/ready register slice that
// computes the next-router route on head flits and replays it for the rest
// of the wormhole packet.
module lookahead_route_unit
    import noc::*;
#(
    parameter int X_BITS   = 3,
    parameter int Y_BITS   = 3,
    parameter int MESH_X   = 8,
    parameter int MESH_Y   = 8,
    parameter int TORUS    = 0,
    parameter int YX_ORDER = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [X_BITS-1:0] pos_x,
    input  logic [Y_BITS-1:0] pos_y,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_head,
    input  logic              in_tail,
    input  logic [X_BITS-1:0] in_dest_x,
    input  logic [Y_BITS-1:0] in_dest_y,
    input  logic [4:0]        in_route,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_head,
    output logic              out_tail,
    output logic [4:0]        out_route,
    output logic [4:0]        out_next_route,
    output logic              err_route,
    output logic              err_proto
);

    logic [X_BITS-1:0] pos_x_q;
    logic [Y_BITS-1:0] pos_y_q;
    logic [4:0]        route_q;
    logic [4:0]        calc_route;
    logic              calc_err;
    logic              accept;
    state_t            state;

    assign in_ready = !rst && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Position is sampled every cycle, reset included, so it is valid as
    // soon as reset drops.
    always_ff @(posedge clk) begin
        pos_x_q <= pos_x;
        pos_y_q <= pos_y;
    end

    lookahead_route_calc #(
        .X_BITS  (X_BITS),
        .Y_BITS  (Y_BITS),
        .MESH_X  (MESH_X),
        .MESH_Y  (MESH_Y),
        .TORUS   (TORUS),
        .YX_ORDER(YX_ORDER)
    ) u_calc (
        .pos_x     (pos_x_q),
        .pos_y     (pos_y_q),
        .route     (in_route),
        .dest_x    (in_dest_x),
        .dest_y    (in_dest_y),
        .next_route(calc_route),
        .route_err (calc_err)
    );

    // Wormhole FSM plus output register slice and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= StIdle;
            route_q        <= goLocal;
            out_valid      <= 1'b0;
            out_head       <= 1'b0;
            out_tail       <= 1'b0;
            out_route      <= goLocal;
            out_next_route <= goLocal;
            err_route      <= 1'b0;
            err_proto      <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_head  <= in_head;
            out_tail  <= in_tail;
            out_route <= in_route;
            if (in_head) begin
                out_next_route <= calc_route;
                route_q        <= calc_route;
                if (calc_err)        err_route <= 1'b1;
                if (state == StPkt)  err_proto <= 1'b1;
                state <= in_tail ? StIdle : StPkt;
            end else begin
                out_next_route <= route_q;
                if (state == StIdle) err_proto <= 1'b1;
                else if (in_tail)    state     <= StIdle;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lookahead_route_unit.sv
// Directed bench: a mesh/YX and a torus/XY instance share all stimulus.
module tb_lookahead_route_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] pos_x = '0, pos_y = '0;
    logic       in_valid = 1'b0, in_head = 1'b0, in_tail = 1'b0;
    logic [2:0] in_dest_x = '0, in_dest_y = '0;
    logic [4:0] in_route = 5'b10000;
    logic       out_ready = 1'b1;

    logic       m_in_ready, m_out_valid, m_out_head, m_out_tail, m_err_route, m_err_proto;
    logic [4:0] m_out_route, m_out_next_route;
    logic       t_in_ready, t_out_valid, t_out_head, t_out_tail, t_err_route, t_err_proto;
    logic [4:0] t_out_route, t_out_next_route;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    lookahead_route_unit #(.TORUS(0), .YX_ORDER(1)) dut_mesh (
        .clk(clk), .rst(rst), .pos_x(pos_x), .pos_y(pos_y),
        .in_valid(in_valid), .in_ready(m_in_ready), .in_head(in_head), .in_tail(in_tail),
        .in_dest_x(in_dest_x), .in_dest_y(in_dest_y), .in_route(in_route),
        .out_valid(m_out_valid), .out_ready(out_ready), .out_head(m_out_head),
        .out_tail(m_out_tail), .out_route(m_out_route), .out_next_route(m_out_next_route),
        .err_route(m_err_route), .err_proto(m_err_proto)
    );

    lookahead_route_unit #(.TORUS(1), .YX_ORDER(0)) dut_torus (
        .clk(clk), .rst(rst), .pos_x(pos_x), .pos_y(pos_y),
        .in_valid(in_valid), .in_ready(t_in_ready), .in_head(in_head), .in_tail(in_tail),
        .in_dest_x(in_dest_x), .in_dest_y(in_dest_y), .in_route(in_route),
        .out_valid(t_out_valid), .out_ready(out_ready), .out_head(t_out_head),
        .out_tail(t_out_tail), .out_route(t_out_route), .out_next_route(t_out_next_route),
        .err_route(t_err_route), .err_proto(t_err_proto)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_flit(input logic v, input logic h, input logic t, input logic [4:0] r,
                            input logic [2:0] dx, input logic [2:0] dy);
        in_valid  = v;
        in_head   = h;
        in_tail   = t;
        in_route  = r;
        in_dest_x = dx;
        in_dest_y = dy;
    endtask

    task automatic do_reset;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rst       = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        n_checks++;
        if ({m_in_ready, t_in_ready} !== 2'b00) begin
            n_fails++;
            $display("[TB] FAIL reset_in_ready: got %b, expected 00", {m_in_ready, t_in_ready});
        end
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if ({m_out_valid, m_out_head, m_out_tail, m_err_route, m_err_proto} !== 5'b0) begin
            n_fails++;
            $display("[TB] FAIL reset_flags: got %b, expected 00000",
                     {m_out_valid, m_out_head, m_out_tail, m_err_route, m_err_proto});
        end
        n_checks++;
        if ({m_out_route, m_out_next_route} !== {5'b10000, 5'b10000}) begin
            n_fails++;
            $display("[TB] FAIL reset_routes: got %b %b, expected 10000 10000",
                     m_out_route, m_out_next_route);
        end
        n_checks++;
        if (m_in_ready !== 1'b1) begin
            n_fails++;
            $display("[TB] FAIL ready_after_reset: got %b, expected 1", m_in_ready);
        end
    endtask

    // Back-to-back single-flit packets from (2,2); mesh YX and torus XY views.
    task automatic test_route_table;
        logic [4:0] rt [8];
        logic [2:0] ddx [8];
        logic [2:0] ddy [8];
        logic [4:0] exp_m [8];
        logic [4:0] exp_t [8];
        rt    = '{5'b01000, 5'b01000, 5'b01000, 5'b01000, 5'b01000, 5'b00001, 5'b10000, 5'b00011};
        ddx   = '{3'd5, 3'd3, 3'd1, 3'd6, 3'd3, 3'd2, 3'd5, 3'd5};
        ddy   = '{3'd4, 3'd0, 3'd2, 3'd2, 3'd2, 3'd1, 3'd4, 3'd4};
        exp_m = '{5'b00010, 5'b00001, 5'b00100, 5'b01000, 5'b10000, 5'b10000, 5'b10000, 5'b10000};
        exp_t = '{5'b01000, 5'b00001, 5'b00100, 5'b01000, 5'b10000, 5'b10000, 5'b10000, 5'b10000};
        do_reset();
        pos_x = 3'd2;
        pos_y = 3'd2;
        tick();
        for (int i = 0; i < 8; i++) begin
            set_flit(1'b1, 1'b1, 1'b1, rt[i], ddx[i], ddy[i]);
            tick();
            n_checks++;
            if ({m_out_valid, m_out_route, m_out_next_route} !== {1'b1, rt[i], exp_m[i]}) begin
                n_fails++;
                $display("[TB] FAIL mesh_route[%0d]: got v=%b r=%b nr=%b, expected v=1 r=%b nr=%b",
                         i, m_out_valid, m_out_route, m_out_next_route, rt[i], exp_m[i]);
            end
            n_checks++;
            if (t_out_next_route !== exp_t[i]) begin
                n_fails++;
                $display("[TB] FAIL torus_xy_route[%0d]: got %b, expected %b",
                         i, t_out_next_route, exp_t[i]);
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if ({m_err_route, m_err_proto, t_err_route, t_err_proto} !== 4'b0) begin
            n_fails++;
            $display("[TB] FAIL table_errors: got %b, expected 0000",
                     {m_err_route, m_err_proto, t_err_route, t_err_proto});
        end
    endtask

    // Torus wrap from (7,0): E wraps to x=0, N wraps to y=7; mesh sees edge hops.
    task automatic test_torus_wrap;
        logic [4:0] rt [7];
        logic [2:0] ddx [7];
        logic [2:0] ddy [7];
        logic [4:0] exp_t [7];
        rt    = '{5'b01000, 5'b01000, 5'b01000, 5'b01000, 5'b01000, 5'b01000, 5'b00001};
        ddx   = '{3'd1, 3'd4, 3'd5, 3'd0, 3'd0, 3'd0, 3'd7};
        ddy   = '{3'd0, 3'd0, 3'd0, 3'd5, 3'd4, 3'd0, 3'd6};
        exp_t = '{5'b01000, 5'b01000, 5'b00100, 5'b00001, 5'b00010, 5'b10000, 5'b00001};
        do_reset();
        pos_x = 3'd7;
        pos_y = 3'd0;
        tick();
        for (int i = 0; i < 7; i++) begin
            set_flit(1'b1, 1'b1, 1'b1, rt[i], ddx[i], ddy[i]);
            tick();
            n_checks++;
            if (t_out_next_route !== exp_t[i]) begin
                n_fails++;
                $display("[TB] FAIL torus_wrap[%0d]: got %b, expected %b",
                         i, t_out_next_route, exp_t[i]);
            end
            n_checks++;
            if (m_out_next_route !== 5'b10000) begin
                n_fails++;
                $display("[TB] FAIL mesh_edge_local[%0d]: got %b, expected 10000",
                         i, m_out_next_route);
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if ({m_err_route, t_err_route} !== 2'b10) begin
            n_fails++;
            $display("[TB] FAIL wrap_err_route: got %b, expected 10", {m_err_route, t_err_route});
        end
    endtask

    // Head/body/body/tail with out_ready toggling; bench tracks the slice.
    task automatic test_wormhole;
        logic       pat [9];
        logic       ev;
        int         exp_idx;
        int         idx;
        logic       can;
        logic       acc;
        pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        pos_x = 3'd2;
        pos_y = 3'd2;
        tick();
        ev      = 1'b0;
        exp_idx = 0;
        idx     = 0;
        for (int c = 0; c < 9; c++) begin
            out_ready = pat[c];
            can = !ev || pat[c];
            if (idx == 0)      set_flit(1'b1, 1'b1, 1'b0, 5'b01000, 3'd5, 3'd4);
            else if (idx < 3)  set_flit(1'b1, 1'b0, 1'b0, 5'b01000, 3'd0, 3'd0);
            else if (idx == 3) set_flit(1'b1, 1'b0, 1'b1, 5'b01000, 3'd0, 3'd0);
            else               set_flit(1'b0, 1'b0, 1'b0, 5'b01000, 3'd0, 3'd0);
            acc = in_valid && can;
            #1;
            n_checks++;
            if (m_in_ready !== can) begin
                n_fails++;
                $display("[TB] FAIL worm_in_ready[%0d]: got %b, expected %b", c, m_in_ready, can);
            end
            tick();
            if (acc) begin
                ev      = 1'b1;
                exp_idx = idx;
                idx++;
            end else if (pat[c]) begin
                ev = 1'b0;
            end
            n_checks++;
            if (m_out_valid !== ev) begin
                n_fails++;
                $display("[TB] FAIL worm_valid[%0d]: got %b, expected %b", c, m_out_valid, ev);
            end else if (ev && ({m_out_head, m_out_tail, m_out_route, m_out_next_route} !==
                                {exp_idx == 0, exp_idx == 3, 5'b01000, 5'b00010})) begin
                n_fails++;
                $display("[TB] FAIL worm_flit[%0d]: got h=%b t=%b r=%b nr=%b, expected flit %0d nr=00010",
                         c, m_out_head, m_out_tail, m_out_route, m_out_next_route, exp_idx);
            end
        end
        out_ready = 1'b1;
        set_flit(1'b1, 1'b1, 1'b1, 5'b01000, 3'd1, 3'd2);
        tick();
        in_valid = 1'b0;
        n_checks++;
        if ({m_err_proto, m_out_next_route} !== {1'b0, 5'b00100}) begin
            n_fails++;
            $display("[TB] FAIL worm_idle_after_tail: got ep=%b nr=%b, expected ep=0 nr=00100",
                     m_err_proto, m_out_next_route);
        end
    endtask

    task automatic test_mesh_edge;
        do_reset();
        pos_x = 3'd0;
        pos_y = 3'd3;
        tick();
        set_flit(1'b1, 1'b1, 1'b1, 5'b00100, 3'd5, 3'd5);
        tick();
        n_checks++;
        if ({m_err_route, m_out_next_route} !== {1'b1, 5'b10000}) begin
            n_fails++;
            $display("[TB] FAIL edge_west: got er=%b nr=%b, expected er=1 nr=10000",
                     m_err_route, m_out_next_route);
        end
        set_flit(1'b1, 1'b1, 1'b1, 5'b01000, 3'd4, 3'd3);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({m_err_route, m_out_next_route} !== {1'b1, 5'b01000}) begin
            n_fails++;
            $display("[TB] FAIL edge_sticky: got er=%b nr=%b, expected er=1 nr=01000",
                     m_err_route, m_out_next_route);
        end
        do_reset();
        n_checks++;
        if (m_err_route !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL edge_cleared: got %b, expected 0", m_err_route);
        end
    endtask

    task automatic test_protocol;
        do_reset();
        set_flit(1'b1, 1'b0, 1'b0, 5'b01000, 3'd5, 3'd4);
        tick();
        in_valid = 1'b0;
        n_checks++;
        if ({m_out_valid, m_err_proto, m_out_next_route} !== {2'b11, 5'b10000}) begin
            n_fails++;
            $display("[TB] FAIL body_in_idle: got v=%b ep=%b nr=%b, expected v=1 ep=1 nr=10000",
                     m_out_valid, m_err_proto, m_out_next_route);
        end
        do_reset();
        pos_x = 3'd2;
        pos_y = 3'd2;
        tick();
        set_flit(1'b1, 1'b1, 1'b0, 5'b01000, 3'd5, 3'd4);
        tick();
        n_checks++;
        if ({m_err_proto, m_out_next_route} !== {1'b0, 5'b00010}) begin
            n_fails++;
            $display("[TB] FAIL first_head: got ep=%b nr=%b, expected ep=0 nr=00010",
                     m_err_proto, m_out_next_route);
        end
        set_flit(1'b1, 1'b1, 1'b0, 5'b01000, 3'd1, 3'd2);
        tick();
        n_checks++;
        if ({m_err_proto, m_out_next_route} !== {1'b1, 5'b00100}) begin
            n_fails++;
            $display("[TB] FAIL head_in_pkt: got ep=%b nr=%b, expected ep=1 nr=00100",
                     m_err_proto, m_out_next_route);
        end
        set_flit(1'b1, 1'b0, 1'b1, 5'b01000, 3'd5, 3'd4);
        tick();
        in_valid = 1'b0;
        n_checks++;
        if ({m_out_tail, m_out_next_route} !== {1'b1, 5'b00100}) begin
            n_fails++;
            $display("[TB] FAIL tail_relatched: got t=%b nr=%b, expected t=1 nr=00100",
                     m_out_tail, m_out_next_route);
        end
    endtask

    task automatic test_reset_mid_packet;
        do_reset();
        pos_x = 3'd2;
        pos_y = 3'd2;
        tick();
        set_flit(1'b1, 1'b1, 1'b0, 5'b01000, 3'd5, 3'd4);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        rst      = 1'b1;
        in_valid = 1'b1;
        #1;
        n_checks++;
        if ({m_out_valid, m_in_ready} !== 2'b10) begin
            n_fails++;
            $display("[TB] FAIL rst_in_ready: got v=%b rdy=%b, expected v=1 rdy=0",
                     m_out_valid, m_in_ready);
        end
        tick();
        n_checks++;
        if (m_out_valid !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL rst_discard: got %b, expected 0", m_out_valid);
        end
        rst       = 1'b0;
        out_ready = 1'b1;
        set_flit(1'b1, 1'b0, 1'b1, 5'b01000, 3'd5, 3'd4);
        tick();
        in_valid = 1'b0;
        n_checks++;
        if ({m_out_valid, m_err_proto, m_out_next_route} !== {2'b11, 5'b10000}) begin
            n_fails++;
            $display("[TB] FAIL rst_to_idle: got v=%b ep=%b nr=%b, expected v=1 ep=1 nr=10000",
                     m_out_valid, m_err_proto, m_out_next_route);
        end
    endtask

    initial begin
        test_reset();
        test_route_table();
        test_torus_wrap();
        test_wormhole();
        test_mesh_edge();
        test_protocol();
        test_reset_mid_packet();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/lookahead_route_unit.md
# lookahead_route_unit

Parametrised, pipelined lookahead routing stage for 2D mesh or torus NoC routers. For each header flit it computes the output port the packet will take at the *next* router, supporting selectable XY/YX dimension order and optional torus wrap-around with shortest-path selection. It latches the result for wormhole body and tail flits and sits between the input buffer and the switch allocator, with one valid/ready register stage.

## Interface
- `X_BITS`, default 3: width of the x coordinate.
- `Y_BITS`, default 3: width of the y coordinate.
- `MESH_X`, default 8: number of columns, 2..2**X_BITS.
- `MESH_Y`, default 8: number of rows, 2..2**Y_BITS.
- `TORUS`, default 0: 1 enables wrap links and shortest-direction routing.
- `YX_ORDER`, default 1: 1 resolves Y before X; 0 resolves X before Y.

Ports (reset is synchronous and active-high):
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `pos_x`, `pos_y` in X_BITS/Y_BITS: this router's coordinates. Static after reset; sampled every cycle.
- `in_valid` in 1: the input flit is valid.
- `in_ready` out 1: the unit accepts the flit this cycle.
- `in_head`, `in_tail` in 1 each: flit type. Both set means a single-flit packet.
- `in_dest_x`, `in_dest_y` in X_BITS/Y_BITS: destination coordinates, meaningful on head flits only.
- `in_route` in 5: one-hot route at this router, computed upstream.
- `out_valid` out 1: output flit valid.
- `out_ready` in 1: downstream accepts.
- `out_head`, `out_tail` out 1 each: registered flit type.
- `out_route` out 5: registered copy of `in_route`.
- `out_next_route` out 5: one-hot route for the next router.
- `err_route` out 1: sticky. Set when a mesh-edge hop is requested or the destination is out of range.
- `err_proto` out 1: sticky. Set on a non-head flit in IDLE, or a head flit in PKT.

## Operation
- Direction encoding: bit 0 N, bit 1 S, bit 2 W, bit 3 E, bit 4 Local.
- North decrements y and East increments x.
- Next position: `pos` is stepped by one hop in the `in_route` direction.
  - Torus: the step is modulo MESH_X/MESH_Y.
  - Mesh: a step off the edge sets `err_route`, and `out_next_route` becomes Local.
  - `in_route` = Local or not one-hot: `out_next_route` = Local.
- Route decision from the next position (np) to the destination (d).
  - YX_ORDER=1: if dy≠0, go N/S; else if dx≠0, go W/E; else Local.
  - YX_ORDER=0: the same with X resolved first.
- Direction choice within a dimension:
  - Mesh: sign of d − np.
  - Torus: compute the forward distance (d − np) mod M, where M is the ring size.
    - If it is ≤ M/2 (integer division), go E/S.
    - Otherwise go W/N.
    - Ties resolve E/S.
- Arithmetic uses X_BITS+1 / Y_BITS+1 bits. `in_dest_x` ≥ MESH_X or `in_dest_y` ≥ MESH_Y sets `err_route`, and the route becomes Local.
- Wormhole FSM:
  - IDLE: an accepted head computes the route and latches it into `route_q`. Go to PKT unless `in_tail` is set.
  - PKT: body flits output `route_q`. An accepted tail outputs `route_q` and returns to IDLE.
  - Head in PKT: set `err_proto`, treat the flit as a new head (recompute and relatch), then apply the rules above.
  - Non-head in IDLE: set `err_proto`, output `route_q`, stay in IDLE.
- Sticky errors clear only on `rst`.

## Timing
- Latency: 1 cycle from an accepted input to `out_valid`. Throughput: 1 flit/cycle.
- `in_ready` = !rst && (!out_valid || out_ready).
- Handshakes:
  - Transfer occurs when valid and ready are both high.
  - While `out_valid` && !`out_ready`, all `out_*` hold stable.
  - `in_ready` is combinational from `out_ready` (no skid buffer).
- Position path: `pos_x/pos_y` are registered before use, giving 1 cycle from a `pos` change to its effect. After `rst` deassertion, the first flit may be accepted in the next cycle.
- Reset values:
  - `out_valid`=0; `out_head`/`out_tail`=0.
  - `out_route`=`out_next_route`=5'b10000.
  - `route_q`=5'b10000; FSM=IDLE.
  - `err_route`=`err_proto`=0.
- Reset mid-packet: the FSM returns to IDLE, and any flit in the pipeline register is discarded.
- Simultaneous output pop and input push: allowed in the same cycle, with the register replaced.

## Structure
- Package `noc` holds:
  - `direction_t`
  - the port index constants (`kNorthPort`…`kLocalPort`)
  - `goNorth`…`goLocal`
  - a parametrised-width xy struct helper
- One natural sub-module, `lookahead_route_calc`: the combinational next-position and route function, parametrised by TORUS/YX_ORDER. The top level holds the FSM, registers and handshake.

## Test plan
- Mesh 8×8, YX: pos (2,2), route E, dest (5,4) → next pos (3,2), `out_next_route`=S (5'b00010), 1 cycle later.
- Torus 8×8, XY: pos (7,0), route E, dest (1,0) → next pos (0,0), forward distance 1 → E. Dest (4,0) from np (0,0), tie → E. Dest (5,0) → W.
- Wormhole: head, body, body, tail with `out_ready` toggling 1,0,1,0 → all four flits carry the head's route, stall cycles hold outputs, and the FSM returns to IDLE.
- Mesh edge: pos (0,3), route W → `err_route`=1, `out_next_route`=Local. The sticky bit persists until `rst`.
- Protocol: body flit in IDLE → `err_proto`=1, output route 5'b10000. A head mid-packet → route recomputed.
- Reset asserted with `out_valid`=1 in PKT → the next cycle shows `out_valid`=0, IDLE, and `in_ready`=0 while `rst` is high.
